// File: rtl/expr_seq_pkg.sv
// Shared types, constants and the result-bus fold used by the expression vector sequencer.
package expr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int TAP0 = 71;
  localparam int TAP1 = 65;
  localparam int TAP2 = 24;
  localparam int TAP3 = 18;

  localparam int Y_W = 90;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] SIG_INIT = 32'hFFFFFFFF;

  // Compacts the 90-bit result bus into one 32-bit word before it enters the MISR.
  function automatic logic [31:0] fold(input logic [Y_W-1:0] y);
    return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

endpackage

// File: rtl/expr_misr.sv
// 32-bit multiple-input signature register fed by the folded result bus.
module expr_misr
  import expr_seq_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           en_i,
  input  logic [Y_W-1:0] y_i,
  output logic [31:0]    sig_o
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;

  // Load takes priority so a relaunch always starts from a clean signature.
  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SIG_INIT;
    end else if (en_i) begin
      sig_d = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? CRC_POLY : 32'h0)) ^ fold(y_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= SIG_INIT;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Drives pseudo-random vectors into one expression unit and signs its results with a MISR.
module expr_vector_sequencer
  import expr_seq_pkg::*;
#(
  parameter int              IN_W    = 72,
  parameter int              OUT_W   = Y_W,
  parameter int              NUM_VEC = 256,
  parameter int              LAT     = 0,
  parameter logic [IN_W-1:0] SEED    = 72'h1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic [31:0]      expected_sig_i,
  output logic [IN_W-1:0]  vec_out_o,
  output logic             vec_valid_o,
  input  logic [OUT_W-1:0] y_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [31:0]      signature_o
);

  localparam logic [IN_W-1:0] SEED_EFF  = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [15:0]     LAST_IDX  = 16'(NUM_VEC - 1);
  localparam logic [15:0]     VEC_TOTAL = 16'(NUM_VEC);

  seq_state_e      state_q, state_d;
  logic [IN_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]     issue_cnt_q, issue_cnt_d;
  logic [15:0]     cap_cnt_q, cap_cnt_d;
  logic            start_ok;
  logic            issue;
  logic            cap_valid;
  logic            capture;
  logic            feedback;

  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign issue    = (state_q == RUN) && !stall_i;
  assign capture  = cap_valid && ((state_q == RUN) || (state_q == DRAIN));
  assign feedback = lfsr_q[TAP0] ^ lfsr_q[TAP1] ^ lfsr_q[TAP2] ^ lfsr_q[TAP3];

  // The accepted start reloads everything, so a relaunch from DONE repeats the run exactly.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    if (capture) begin
      cap_cnt_d = cap_cnt_q + 16'd1;
    end
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = RUN;
          lfsr_d      = SEED_EFF;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall_i) begin
          lfsr_d      = {lfsr_q[IN_W-2:0], feedback};
          issue_cnt_d = issue_cnt_q + 16'd1;
          if (issue_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cap_cnt_q == VEC_TOTAL) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_EFF;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  // The unit never stalls, so the valid delay line shifts every cycle regardless of stall_i.
  generate
    if (LAT == 0) begin : g_no_lat
      assign cap_valid = issue;
    end else begin : g_lat
      logic [LAT-1:0] pipe_q;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          pipe_q <= '0;
        end else if (start_ok) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= (pipe_q << 1) | LAT'(issue);
        end
      end
      assign cap_valid = pipe_q[LAT-1];
    end
  endgenerate

  expr_misr u_misr (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .load_i (start_ok),
    .en_i   (capture),
    .y_i    (y_in_i),
    .sig_o  (signature_o)
  );

  assign vec_out_o   = lfsr_q;
  assign vec_valid_o = issue;
  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign pass_o      = done_o && (signature_o == expected_sig_i);

endmodule
